// File: rtl/seg7_capture_pkg.sv
// Shared constants and types for seg7_capture: segment encodings, bit order,
// pattern/digit typedefs and the settle FSM state encoding.
package seg7_capture_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned PAT_W      = NUM_DIGITS * SEG_W;
  localparam int unsigned CNT_W      = 8;

  // Bit position of each segment inside a 7-bit digit pattern {g,f,e,d,c,b,a}.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low encodings (0 = segment lit).
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h18;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef logic [PAT_W-1:0] pattern_t;
  typedef logic [BCD_W-1:0] bcd_digit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } settle_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment pattern to a BCD digit.
// Illegal patterns (including blank) flag illegal and return digit 0.
module seg7_to_bcd
  import seg7_capture_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic             illegal_o_c,
  output bcd_digit_t       digit_o_c
);

  always_comb begin
    illegal_o_c = 1'b0;
    digit_o_c   = '0;
    case (pat_i)
      SEG_0:   digit_o_c = 4'd0;
      SEG_1:   digit_o_c = 4'd1;
      SEG_2:   digit_o_c = 4'd2;
      SEG_3:   digit_o_c = 4'd3;
      SEG_4:   digit_o_c = 4'd4;
      SEG_5:   digit_o_c = 4'd5;
      SEG_6:   digit_o_c = 4'd6;
      SEG_7:   digit_o_c = 4'd7;
      SEG_8:   digit_o_c = 4'd8;
      SEG_9:   digit_o_c = 4'd9;
      default: illegal_o_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples four active-low 7-segment digits, waits for a stable pattern, decodes
// it to BCD and offers it on valid/ready. Define SEG7_CAPTURE_SYNC_EN to insert a
// two-flop input synchroniser (adds 2 cycles of latency).
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic [3:0]  c,
  input  logic [3:0]  d,
  input  logic [3:0]  e,
  input  logic [3:0]  f,
  input  logic [3:0]  g,
  input  logic        ready,
  output logic [15:0] bcd,
  output logic        valid,
  output logic [3:0]  digit_err,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  pattern_t raw_c;
  pattern_t s_c;

  // Gather the per-segment buses into per-digit {g..a} patterns.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_pack
    assign raw_c[i*SEG_W + SEG_A] = a[i];
    assign raw_c[i*SEG_W + SEG_B] = b[i];
    assign raw_c[i*SEG_W + SEG_C] = c[i];
    assign raw_c[i*SEG_W + SEG_D] = d[i];
    assign raw_c[i*SEG_W + SEG_E] = e[i];
    assign raw_c[i*SEG_W + SEG_F] = f[i];
    assign raw_c[i*SEG_W + SEG_G] = g[i];
  end

`ifdef SEG7_CAPTURE_SYNC_EN
  pattern_t sync1_q;
  pattern_t sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = sync2_q;
`else
  assign s_c = raw_c;
`endif

  settle_state_e          state_q, state_d;
  pattern_t               cand_q, cand_d;
  pattern_t               last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            bcd_q, bcd_d;
  logic                   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]  err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic                   accept_c;

  logic [NUM_DIGITS-1:0]  illegal_c;
  logic [15:0]            dec_c;

  // Decode the candidate so the result is ready on the accepting edge.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_to_bcd u_dec (
      .pat_i       (cand_q[i*SEG_W +: SEG_W]),
      .illegal_o_c (illegal_c[i]),
      .digit_o_c   (dec_c[i*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '1;
      last_q  <= '1;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    accept_c = 1'b0;
    valid_d  = valid_q && !ready;

    // A changed sample restarts the stability count; returning to the last
    // accepted pattern needs no new accept.
    if (s_c != cand_q) begin
      cand_d  = s_c;
      cnt_d   = '0;
      state_d = (s_c != last_q) ? ST_SETTLE : ST_IDLE;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        accept_c = 1'b1;
        state_d  = ST_IDLE;
      end
    end

    if (accept_c) begin
      last_d = cand_q;
      err_d  = illegal_c;
      if (illegal_c == '0) begin
        if (valid_q && !ready) begin
          ovr_d = 1'b1;
        end
        bcd_d   = dec_c;
        valid_d = 1'b1;
      end
    end
  end

  assign bcd       = bcd_q;
  assign valid     = valid_q;
  assign digit_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random patterns,
// compared each cycle against a run-length based reference model.
module tb_seg7_capture;

  localparam int SC = 4;
`ifdef SEG7_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int SETTLE_N = SC + 1 + LAT;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  a, b, c, d, e, f, g;
  logic        ready;
  logic [15:0] bcd;
  logic        valid;
  logic [3:0]  digit_err;
  logic        overrun;

  seg7_capture #(.STABLE_CYCLES(SC)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .ready     (ready),
    .bcd       (bcd),
    .valid     (valid),
    .digit_err (digit_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  // Reference model state
  logic [27:0] m_prev, m_last, m_sy1, m_sy2;
  int          m_run;
  logic [15:0] m_bcd;
  logic        m_valid;
  logic [3:0]  m_err;
  logic        m_ovr;

  function automatic logic [27:0] pat4(input logic [6:0] p3, input logic [6:0] p2,
                                       input logic [6:0] p1, input logic [6:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  task automatic drive(input logic [27:0] s);
    for (int i = 0; i < 4; i++) begin
      a[i] = s[7*i + 0];
      b[i] = s[7*i + 1];
      c[i] = s[7*i + 2];
      d[i] = s[7*i + 3];
      e[i] = s[7*i + 4];
      f[i] = s[7*i + 5];
      g[i] = s[7*i + 6];
    end
  endtask

  task automatic model_reset();
    m_prev  = '1;
    m_last  = '1;
    m_sy1   = '1;
    m_sy2   = '1;
    m_run   = 0;
    m_bcd   = '0;
    m_valid = 1'b0;
    m_err   = '0;
    m_ovr   = 1'b0;
  endtask

  // A pattern is taken once it has been seen on SC+1 consecutive edges and
  // differs from the last pattern taken.
  task automatic model_edge(input logic [27:0] raw, input logic rdy);
    logic [27:0] s;
    logic [15:0] dig;
    logic [3:0]  err;
    logic        was_blocked;
    logic        found;
`ifdef SEG7_CAPTURE_SYNC_EN
    s     = m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = raw;
`else
    s = raw;
`endif
    if (s == m_prev) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_prev = s;
      m_run  = 1;
    end
    was_blocked = m_valid && !rdy;
    if (m_valid && rdy) m_valid = 1'b0;
    if (m_run == SC + 1 && s != m_last) begin
      m_last = s;
      dig    = '0;
      err    = '0;
      for (int i = 0; i < 4; i++) begin
        found = 1'b0;
        for (int j = 0; j < 10; j++) begin
          if (lut[j] == s[7*i +: 7]) begin
            dig[4*i +: 4] = 4'(j);
            found         = 1'b1;
          end
        end
        err[i] = !found;
      end
      m_err = err;
      if (err == 4'd0) begin
        if (was_blocked) m_ovr = 1'b1;
        m_bcd   = dig;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bcd"},       32'(bcd),       32'(m_bcd));
    chk({tag, ".valid"},     32'(valid),     32'(m_valid));
    chk({tag, ".digit_err"}, 32'(digit_err), 32'(m_err));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic cycle(input string tag, input logic [27:0] raw, input logic rdy);
    drive(raw);
    ready = rdy;
    @(posedge clock);
    model_edge(raw, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic hold(input string tag, input logic [27:0] raw, input logic rdy, input int n);
    for (int k = 0; k < n; k++) cycle(tag, raw, rdy);
  endtask

  logic [27:0] p0000, p1259, pglitch, pblank, p1359, p1111, p4678, p9999, rp;

  initial begin
    p0000   = pat4(7'h40, 7'h40, 7'h40, 7'h40);
    p1259   = pat4(7'h79, 7'h24, 7'h12, 7'h18);
    pglitch = pat4(7'h79, 7'h24, 7'h12, 7'h00);
    pblank  = pat4(7'h79, 7'h7F, 7'h12, 7'h18);
    p1359   = pat4(7'h79, 7'h30, 7'h12, 7'h18);
    p1111   = pat4(7'h79, 7'h79, 7'h79, 7'h79);
    p4678   = pat4(7'h19, 7'h02, 7'h78, 7'h00);
    p9999   = pat4(7'h18, 7'h18, 7'h18, 7'h18);

    reset_n = 1'b0;
    ready   = 1'b0;
    drive('1);
    model_reset();
    #12;
    check_all("por");
    reset_n = 1'b1;

    // 00:00 accepted once, then held without re-accept
    hold("z0000", p0000, 1'b0, SETTLE_N);
    chk("z0000.lit_bcd", 32'(bcd), 32'h0000);
    chk("z0000.lit_valid", 32'(valid), 32'd1);
    hold("z0000_hold", p0000, 1'b0, 6);

    // 12:59 with ready high: one-cycle valid
    hold("z1259", p1259, 1'b1, SETTLE_N);
    chk("z1259.lit_bcd", 32'(bcd), 32'h1259);
    chk("z1259.lit_valid", 32'(valid), 32'd1);
    cycle("z1259_x", p1259, 1'b1);
    chk("z1259.lit_drop", 32'(valid), 32'd0);

    // short glitch on digit0 then restore: nothing changes
    hold("glitch", pglitch, 1'b1, SC - 1);
    hold("restore", p1259, 1'b1, SETTLE_N + 2);
    chk("glitch.lit_valid", 32'(valid), 32'd0);
    chk("glitch.lit_bcd", 32'(bcd), 32'h1259);

    // blank digit2 is illegal, then legal 3
    hold("blank", pblank, 1'b0, SETTLE_N);
    chk("blank.lit_err", 32'(digit_err), 32'h4);
    chk("blank.lit_valid", 32'(valid), 32'd0);
    hold("z1359", p1359, 1'b0, SETTLE_N);
    chk("z1359.lit_err", 32'(digit_err), 32'h0);
    chk("z1359.lit_bcd", 32'(bcd), 32'h1359);

    // two more accepts while blocked: latest wins, overrun sticks
    hold("ovr1", p1111, 1'b0, SETTLE_N);
    chk("ovr1.lit_ovr", 32'(overrun), 32'd1);
    hold("ovr2", p4678, 1'b0, SETTLE_N);
    chk("ovr2.lit_bcd", 32'(bcd), 32'h4678);
    cycle("ovr_xfer", p4678, 1'b1);
    chk("ovr_xfer.lit_valid", 32'(valid), 32'd0);
    hold("ovr_idle", p4678, 1'b1, 3);
    chk("ovr_idle.lit_ovr", 32'(overrun), 32'd1);

    // reset while valid=1 and mid-settle
    hold("pre_rst", p0000, 1'b0, SETTLE_N);
    hold("settling", p9999, 1'b0, 2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.lit_valid", 32'(valid), 32'd0);
    chk("async_rst.lit_ovr", 32'(overrun), 32'd0);
    @(posedge clock);
    #1;
    check_all("rst_held");
    #2;
    reset_n = 1'b1;
    hold("post_rst", p9999, 1'b0, SETTLE_N - 1);
    chk("post_rst.lit_early", 32'(valid), 32'd0);
    cycle("post_rst_acc", p9999, 1'b0);
    chk("post_rst.lit_bcd", 32'(bcd), 32'h9999);
    chk("post_rst.lit_valid", 32'(valid), 32'd1);

    // random patterns, hold lengths around the threshold, random ready
    for (int seg = 0; seg < 120; seg++) begin
      int n;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) rp[7*i +: 7] = 7'($urandom);
        else                           rp[7*i +: 7] = lut[$urandom_range(0, 9)];
      end
      n = $urandom_range(1, SC + LAT + 4);
      for (int k = 0; k < n; k++) cycle("rand", rp, 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
